serial_add_sequencer: RTL and testbench
=======================================

Name: serial_add_sequencer

Overview:
Bit-serial addition controller. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then steps a single shared one-bit add cell (two half adders plus an OR for carry) across the operands, LSB first, one bit per clock. The result is presented over a second valid/ready handshake. It sits between operand producers and the result consumer, trading area for WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort; returns FSM to IDLE.
start_valid  input  1  operands present.
start_ready  output  1  block can accept operands.
a_in  input  WIDTH  operand A, sampled only at start handshake.
b_in  input  WIDTH  operand B, sampled only at start handshake.
cin  input  1  carry-in, sampled only at start handshake.
busy  output  1  high in RUN.
done_valid  output  1  result available.
done_ready  input  1  consumer takes result.
sum_out  output  WIDTH  registered sum.
cout  output  1  registered final carry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; start_ready=1; busy=0; done_valid=0; sum_out=0; cout=0.
  - Internal shift registers, carry flop and bit counter all 0.
- FSM states IDLE, RUN, DONE. All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- start_ready = (state==IDLE). busy = (state==RUN). done_valid = (state==DONE).
- IDLE:
  - On a clock edge with start_valid&&start_ready, capture a_in, b_in, cin into working registers.
  - Set bit counter=0 and go to RUN.
- RUN:
  - Each edge feeds bit 0 of the A and B shift registers plus the carry flop to the add cell.
  - Shift the sum bit into the MSB of the sum shift register; shift A and B right by 1; update the carry flop; increment the counter.
  - The edge that processes bit WIDTH-1 also loads sum_out from the completed sum and cout from the final carry, then goes to DONE.
- Latency: handshake at edge k leads to done_valid high after edge k+WIDTH (exactly WIDTH RUN cycles).
- DONE:
  - Hold sum_out/cout.
  - On an edge with done_ready=1, go to IDLE. start_ready rises the next cycle, so there is no same-cycle re-accept.
- Arithmetic:
  - {cout,sum_out} = a + b + cin, modulo 2^(WIDTH+1).
  - Unsigned; no overflow flag.
- sum_out/cout change only on the RUN->DONE edge (and reset). They hold their last result through IDLE and during the next RUN.
- start_valid outside IDLE is ignored; a_in/b_in changes outside the handshake edge have no effect.
- done_ready outside DONE is ignored.
- clear:
  - From any state, the next edge goes to IDLE; done_valid drops and the counter is zeroed.
  - sum_out/cout keep their previous values.
  - clear has priority over both handshakes in the same cycle; operands are not captured.
- WIDTH=1: RUN lasts one cycle; the counter still terminates correctly.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; a partial result is never presented.

Test Plan:
- WIDTH=8, a=8'h12, b=8'h34, cin=0 -> sum_out=8'h46, cout=0; done_valid rises exactly 8 edges after the start handshake; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum_out=8'hFF, cout=1.
- Hold done_ready=0 for 5 cycles in DONE -> done_valid and result stable; start_valid pulses ignored (start_ready=0). Then done_ready=1 -> IDLE, start_ready=1 next cycle.
- Change a_in/b_in every cycle during RUN -> result equals the operands captured at the handshake only.
- Assert clear at RUN cycle 3 -> IDLE next edge, done_valid never rises, sum_out keeps the prior result. Repeat with rst_n low mid-RUN -> all outputs 0 immediately.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum_out=1, cout=1, done_valid one edge after the handshake. Randomised 1000-operation run against a+b+cin with random done_ready backpressure.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: captures two operands plus carry-in, then walks a
// single full-adder cell across them LSB first, one bit per clock.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] sumShift_q, sumShift_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             startReady_q, startReady_d;
  logic             busy_q, busy_d;
  logic             doneValid_q, doneValid_d;

  logic             halfSum, halfCarry, sumBit, carryBit, lastBit;
  logic [WIDTH-1:0] sumShifted;

  // Shared add cell: two half adders with their carries ORed together.
  assign halfSum   = aShift_q[0] ^ bShift_q[0];
  assign halfCarry = aShift_q[0] & bShift_q[0];
  assign sumBit    = halfSum ^ carry_q;
  assign carryBit  = halfCarry | (halfSum & carry_q);
  assign lastBit   = (count_q == LAST_BIT);

  // Written as shift-then-patch so a one-bit WIDTH needs no special slice.
  always_comb begin
    sumShifted = sumShift_q >> 1;
    sumShifted[WIDTH-1] = sumBit;
  end

  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    sumShift_d = sumShift_q;
    carry_d    = carry_q;
    count_d    = count_q;
    sum_d      = sum_q;
    cout_d     = cout_q;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            aShift_d = a_in;
            bShift_d = b_in;
            carry_d  = cin;
            count_d  = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          aShift_d   = aShift_q >> 1;
          bShift_d   = bShift_q >> 1;
          sumShift_d = sumShifted;
          carry_d    = carryBit;
          count_d    = count_q + CW'(1);
          if (lastBit) begin
            sum_d   = sumShifted;
            cout_d  = carryBit;
            state_d = DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    startReady_d = (state_d == IDLE);
    busy_d       = (state_d == RUN);
    doneValid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      aShift_q     <= '0;
      bShift_q     <= '0;
      sumShift_q   <= '0;
      carry_q      <= 1'b0;
      count_q      <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      startReady_q <= 1'b1;
      busy_q       <= 1'b0;
      doneValid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      aShift_q     <= aShift_d;
      bShift_q     <= bShift_d;
      sumShift_q   <= sumShift_d;
      carry_q      <= carry_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      startReady_q <= startReady_d;
      busy_q       <= busy_d;
      doneValid_q  <= doneValid_d;
    end
  end

  assign start_ready = startReady_q;
  assign busy        = busy_q;
  assign done_valid  = doneValid_q;
  assign sum_out     = sum_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: an 8-bit and a 1-bit instance,
// vector table plus scoreboarded random traffic with done_ready backpressure.
module tb_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       clear8, startValid8, cin8, doneReady8;
  logic [7:0] a8, b8;
  logic       startReady8, busy8, doneValid8, cout8;
  logic [7:0] sum8;

  logic       clear1, startValid1, cin1, doneReady1;
  logic [0:0] a1, b1;
  logic       startReady1, busy1, doneValid1, cout1;
  logic [0:0] sum1;

  int         numVectors = 0;
  int         numMiscompares = 0;
  logic [8:0] expQ[$];
  logic [8:0] lastResult = 9'd0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
    int         hold;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear8),
    .start_valid(startValid8), .start_ready(startReady8),
    .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done_valid(doneValid8), .done_ready(doneReady8),
    .sum_out(sum8), .cout(cout8)
  );

  serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1),
    .start_valid(startValid1), .start_ready(startReady1),
    .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done_valid(doneValid1), .done_ready(doneReady1),
    .sum_out(sum1), .cout(cout1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One full transaction on the 8-bit instance; called and returns at a negedge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic [8:0] expected, input int hold, input bit scramble);
    int waited;
    int busyCycles;
    logic [8:0] want;
    checkOutput("start_ready before op", {31'd0, startReady8}, 32'd1);
    a8 = a; b8 = b; cin8 = c; startValid8 = 1'b1;
    expQ.push_back(expected);
    @(negedge clk);
    startValid8 = 1'b0;
    waited = 0;
    busyCycles = 0;
    while (!doneValid8 && waited < 64) begin
      if (busy8) busyCycles++;
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        doneReady8 = 1'($urandom);
      end
      @(negedge clk);
      waited++;
    end
    doneReady8 = 1'b0;
    checkOutput("done latency", waited, 32'd8);
    checkOutput("busy cycles", busyCycles, 32'd8);
    if (!doneValid8) begin
      void'(expQ.pop_front());
      clear8 = 1'b1;
      @(negedge clk);
      clear8 = 1'b0;
      return;
    end
    want = expQ.pop_front();
    checkOutput("result", {23'd0, cout8, sum8}, {23'd0, want});
    for (int i = 0; i < hold; i++) begin
      startValid8 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      checkOutput("hold done_valid", {31'd0, doneValid8}, 32'd1);
      checkOutput("hold start_ready", {31'd0, startReady8}, 32'd0);
      checkOutput("hold result", {23'd0, cout8, sum8}, {23'd0, want});
    end
    // start_valid stays high across the release edge: it must not be taken there.
    startValid8 = 1'b1;
    doneReady8 = 1'b1;
    @(negedge clk);
    startValid8 = 1'b0;
    doneReady8 = 1'b0;
    checkOutput("release done_valid", {31'd0, doneValid8}, 32'd0);
    checkOutput("release start_ready", {31'd0, startReady8}, 32'd1);
    checkOutput("release busy", {31'd0, busy8}, 32'd0);
    lastResult = want;
  endtask

  task automatic runOne1(input logic a, input logic b, input logic c, input logic [1:0] expected);
    a1 = a; b1 = b; cin1 = c; startValid1 = 1'b1;
    @(negedge clk);
    startValid1 = 1'b0;
    checkOutput("w1 busy", {31'd0, busy1}, 32'd1);
    checkOutput("w1 early done", {31'd0, doneValid1}, 32'd0);
    @(negedge clk);
    checkOutput("w1 done_valid", {31'd0, doneValid1}, 32'd1);
    checkOutput("w1 result", {30'd0, cout1, sum1}, {30'd0, expected});
    doneReady1 = 1'b1;
    @(negedge clk);
    doneReady1 = 1'b0;
    checkOutput("w1 start_ready", {31'd0, startReady1}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sawDone;
    logic [7:0] ra, rb;
    logic rc;

    vecs[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 5};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 2};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 3};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0};

    rst_n = 1'b0;
    clear8 = 1'b0; startValid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; doneReady8 = 1'b0;
    clear1 = 1'b0; startValid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; doneReady1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset start_ready", {31'd0, startReady8}, 32'd1);
    checkOutput("reset busy", {31'd0, busy8}, 32'd0);
    checkOutput("reset done_valid", {31'd0, doneValid8}, 32'd0);
    checkOutput("reset result", {23'd0, cout8, sum8}, 32'd0);
    checkOutput("w1 reset result", {30'd0, cout1, sum1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].expCout, vecs[i].expSum}, vecs[i].hold, 1'b0);
    end

    // Operands and done_ready wiggle every RUN cycle; only the handshake values count.
    applyStimulus(8'h3C, 8'hC4, 1'b1, 9'h101, 1, 1'b1);
    applyStimulus(8'h21, 8'h43, 1'b0, 9'h064, 0, 1'b1);

    // clear on the third RUN cycle
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; startValid8 = 1'b1;
    @(negedge clk);
    startValid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    checkOutput("clear busy", {31'd0, busy8}, 32'd0);
    checkOutput("clear start_ready", {31'd0, startReady8}, 32'd1);
    checkOutput("clear keeps result", {23'd0, cout8, sum8}, {23'd0, lastResult});
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (doneValid8) sawDone++;
    end
    checkOutput("clear no done", sawDone, 32'd0);

    // clear beats a start handshake in the same cycle
    clear8 = 1'b1; startValid8 = 1'b1; a8 = 8'h55; b8 = 8'h55;
    @(negedge clk);
    clear8 = 1'b0; startValid8 = 1'b0;
    checkOutput("clear vs start busy", {31'd0, busy8}, 32'd0);
    checkOutput("clear vs start ready", {31'd0, startReady8}, 32'd1);

    // asynchronous reset in the middle of RUN
    a8 = 8'h0F; b8 = 8'hF0; cin8 = 1'b1; startValid8 = 1'b1;
    @(negedge clk);
    startValid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async rst busy", {31'd0, busy8}, 32'd0);
    checkOutput("async rst start_ready", {31'd0, startReady8}, 32'd1);
    checkOutput("async rst done_valid", {31'd0, doneValid8}, 32'd0);
    checkOutput("async rst result", {23'd0, cout8, sum8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lastResult = 9'd0;
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (doneValid8) sawDone++;
    end
    checkOutput("rst no partial done", sawDone, 32'd0);

    runOne1(1'b1, 1'b1, 1'b1, 2'b11);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] combo;
      combo = 3'(i);
      runOne1(combo[2], combo[1], combo[0], 2'({1'b0, combo[2]} + {1'b0, combo[1]} + {1'b0, combo[0]}));
    end

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, int'($urandom_range(0, 3)), 1'($urandom));
    end

    checkOutput("scoreboard drained", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
